// File: rtl/ws_mesh_engine.sv
// Weight-stationary systolic matrix-multiply engine: skewed input feed, ROWSxCOLS PE mesh,
// output deskew, shadow weight bank swapped only while the pipeline is empty.
module ws_mesh_engine #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid,
    input  logic                    w_signed,
    input  logic [COLS*DATA_W-1:0]  w_data,
    input  logic                    in_valid,
    input  logic [ROWS*DATA_W-1:0]  in_data,
    output logic                    out_valid,
    output logic [COLS*ACC_W-1:0]   out_data,
    output logic                    w_ready,
    output logic                    w_pending,
    output logic                    busy,
    output logic                    err
);

    localparam int LAT = ROWS + COLS;
    localparam int CW  = $clog2(ROWS + 1);
    localparam int FW  = $clog2(LAT + 2);

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_FULL} wstate_t;

    wstate_t         state, state_nx;
    logic [CW-1:0]   row_cnt, row_cnt_nx;
    logic            sh_we, sh_mode_we, w_err;
    logic [CW-1:0]   sh_row;
    logic            launch, swap;

    logic [DATA_W-1:0] sh_w  [ROWS][COLS];
    logic [DATA_W-1:0] act_w [ROWS][COLS];
    logic              sh_signed, act_signed;

    logic [FW-1:0]     inflight;
    logic [LAT-1:0]    vs;

    logic [DATA_W-1:0] x_lane [ROWS];
    logic [DATA_W-1:0] x_in   [ROWS][COLS];
    logic [DATA_W-1:0] xr     [ROWS][COLS];
    logic [ACC_W-1:0]  p_in   [ROWS][COLS];
    logic [ACC_W-1:0]  ps     [ROWS][COLS];
    logic [ACC_W-1:0]  col_al [COLS];

    // Operands widened to 2*DATA_W+2 so one signed multiply serves both modes.
    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              sgn);
        logic signed [2*DATA_W+1:0]       sa, sb, p;
        logic        [ACC_W+2*DATA_W+1:0] e;
        sa = {{(DATA_W+2){sgn & a[DATA_W-1]}}, a};
        sb = {{(DATA_W+2){sgn & b[DATA_W-1]}}, b};
        p  = sa * sb;
        e  = {{ACC_W{p[2*DATA_W+1]}}, p};
        return e[ACC_W-1:0];
    endfunction

    assign launch    = in_valid && w_ready;
    assign busy      = (inflight != '0);
    assign w_pending = (state == W_FULL);
    assign swap      = (state == W_FULL) && !busy && !in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= W_IDLE;
            row_cnt <= '0;
        end else begin
            state   <= state_nx;
            row_cnt <= row_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        row_cnt_nx = row_cnt;
        sh_we      = 1'b0;
        sh_mode_we = 1'b0;
        sh_row     = row_cnt;
        w_err      = 1'b0;
        case (state)
            W_IDLE: begin
                if (w_valid) begin
                    sh_we      = 1'b1;
                    sh_mode_we = 1'b1;
                    sh_row     = '0;
                    row_cnt_nx = CW'(1);
                    state_nx   = (ROWS == 1) ? W_FULL : W_LOAD;
                end
            end
            W_LOAD: begin
                if (w_valid) begin
                    sh_we      = 1'b1;
                    row_cnt_nx = row_cnt + 1'b1;
                    if (row_cnt == CW'(ROWS - 1))
                        state_nx = W_FULL;
                end
            end
            W_FULL: begin
                if (w_valid)
                    w_err = 1'b1;
                if (swap)
                    state_nx = W_IDLE;
            end
            default: state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned n = 0; n < COLS; n++) begin
                    sh_w[r][n]  <= '0;
                    act_w[r][n] <= '0;
                end
            sh_signed  <= 1'b0;
            act_signed <= 1'b0;
            w_ready    <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < ROWS; r++)
                if (sh_we && sh_row == CW'(r))
                    for (int unsigned n = 0; n < COLS; n++)
                        sh_w[r][n] <= w_data[n*DATA_W +: DATA_W];
            if (sh_mode_we)
                sh_signed <= w_signed;
            if (swap) begin
                act_w      <= sh_w;
                act_signed <= sh_signed;
                w_ready    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (launch && !out_valid)
                inflight <= inflight + 1'b1;
            else if (!launch && out_valid)
                inflight <= inflight - 1'b1;
            if (w_err || (in_valid && !w_ready))
                err <= 1'b1;
        end
    end

    // Lane k passes through k+1 registers so it meets PE row k at the right cycle.
    for (genvar k = 0; k < ROWS; k++) begin : g_skew
        logic [DATA_W-1:0] sq [k+1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i <= k; i++)
                    sq[i] <= '0;
            end else begin
                sq[0] <= launch ? in_data[k*DATA_W +: DATA_W] : '0;
                for (int unsigned i = 1; i <= k; i++)
                    sq[i] <= sq[i-1];
            end
        end
        assign x_lane[k] = sq[k];
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_row
        for (genvar n = 0; n < COLS; n++) begin : g_col
            if (n == 0) begin : g_xl
                assign x_in[k][n] = x_lane[k];
            end else begin : g_xr
                assign x_in[k][n] = xr[k][n-1];
            end
            if (k == 0) begin : g_p0
                assign p_in[k][n] = '0;
            end else begin : g_pn
                assign p_in[k][n] = ps[k-1][n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < ROWS; k++)
                for (int unsigned n = 0; n < COLS; n++) begin
                    xr[k][n] <= '0;
                    ps[k][n] <= '0;
                end
        end else begin
            for (int unsigned k = 0; k < ROWS; k++)
                for (int unsigned n = 0; n < COLS; n++) begin
                    xr[k][n] <= x_in[k][n];
                    ps[k][n] <= p_in[k][n] + mul_ext(x_in[k][n], act_w[k][n], act_signed);
                end
        end
    end

    // Column n leaves the mesh n cycles late; pad it by COLS-1-n to realign.
    for (genvar n = 0; n < COLS; n++) begin : g_dsk
        localparam int D = COLS - 1 - n;
        if (D == 0) begin : g_nd
            assign col_al[n] = ps[ROWS-1][n];
        end else begin : g_d
            logic [ACC_W-1:0] dq [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < D; i++)
                        dq[i] <= '0;
                end else begin
                    dq[0] <= ps[ROWS-1][n];
                    for (int unsigned i = 1; i < D; i++)
                        dq[i] <= dq[i-1];
                end
            end
            assign col_al[n] = dq[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            vs        <= {vs[LAT-2:0], launch};
            out_valid <= vs[LAT-1];
            for (int unsigned n = 0; n < COLS; n++)
                out_data[n*ACC_W +: ACC_W] <= vs[LAT-1] ? col_al[n] : '0;
        end
    end

endmodule

// File: doc/ws_mesh_engine.md
# ws_mesh_engine

Parametrised weight-stationary systolic matrix-multiply engine, successor to the fixed square mesh. It supports rectangular ROWS×COLS arrays and a runtime signed/unsigned mode. Image rows stream continuously, one vector per cycle with gaps allowed, and results leave through a built-in deskew stage as one aligned row per cycle. A shadow weight bank lets the next weight matrix load while the current stream is still in flight. The block sits between the input staging logic and the result writeback path.

## Interface
- DATA_W, 8: width of each image and weight element.
- ROWS, 4: reduction depth K; number of PE rows and image lanes.
- COLS, 4: output channels N; number of PE columns and output lanes.
- ACC_W, 32: accumulator and output lane width; must be ≥ 2*DATA_W.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_valid  in  1  weight beat present.
- w_signed  in  1  operand mode for this matrix; sampled on its first beat.
- w_data  in  COLS*DATA_W  weight row r (beat r): lane n = W[r][n].
- in_valid  in  1  image vector present.
- in_data  in  ROWS*DATA_W  lane k = x[k].
- out_valid  out  1  result row present.
- out_data  out  COLS*ACC_W  lane n = Σk x[k]·W[k][n].
- w_ready  out  1  active weight bank valid.
- w_pending  out  1  complete matrix held in shadow bank, awaiting swap.
- busy  out  1  at least one vector in flight.
- err  out  1  sticky error flag.

## Operation
- Weight load FSM states: W_IDLE, W_LOAD, W_FULL.
  - W_IDLE: w_valid writes beat 0 into shadow row 0, sets row counter to 1, latches w_signed, and moves to W_LOAD.
  - W_LOAD: each w_valid writes the next shadow row. When the counter reaches ROWS the FSM moves to W_FULL and w_pending=1. Gaps in w_valid are allowed.
  - W_FULL: any w_valid sets err, and the beat is dropped.
- Swap: on the first cycle where w_pending=1, busy=0 and in_valid=0:
  - the shadow bank and mode copy to the active bank;
  - w_ready=1, w_pending=0, and the FSM returns to W_IDLE.
- Swap is never taken while any vector is in flight. Results always use the weights active when the vector entered.
- Stream:
  - in_valid with w_ready=1 launches the vector. Lane k is skewed by k cycles into PE row k, and partial sums flow down each column.
  - Column n output is delayed by COLS-1-n cycles in the deskew stage so all lanes exit together.
  - in_valid with w_ready=0 sets err, and the vector is dropped.
- Bubbles: a cycle without in_valid propagates as a cycle without out_valid. Order is preserved and there is no backpressure.
- Arithmetic:
  - The product is 2*DATA_W bits, signed or unsigned per the active mode.
  - It is sign- or zero-extended to ACC_W, and sums wrap modulo 2^ACC_W.
  - out_data is zero whenever out_valid=0.
- busy: an in-flight counter, +1 per launch and −1 per out_valid, both allowed in the same cycle. busy = (count≠0).
- err: sticky until rst.

## Timing
- Reset (rst high at an edge):
  - all outputs go to 0, and out_data goes to 0;
  - weight FSM to W_IDLE, both banks cleared, in-flight pipeline flushed;
  - a stream in progress is discarded and produces no output.
- Latency: a vector sampled at edge t gives out_valid at edge t+ROWS+COLS (8 at defaults). The result is registered.
- Throughput: one vector per cycle sustained, no gaps required.
- Weight beat at edge t: a swap is possible at the earliest at edge t+1 after the final beat, with w_ready/w_pending updating on that edge.
- Final beat coinciding with an in_valid launch: that vector uses the old weights, and the swap waits for drain.
- in_valid in the same cycle the swap would occur: the swap is deferred and the vector uses the old bank. The swap happens at the first idle cycle.

## Test plan
- Identity: load W=I (4 beats, unsigned); x={1,2,3,4} at edge t → out_valid at t+8, lanes {1,2,3,4}; busy high t+1..t+8.
- Mode: load all-0xFF weights with x={1,1,1,1}. Signed gives every lane 0xFFFFFFFC. Unsigned gives every lane 0x000003FC.
- Streaming: 4 back-to-back vectors, then a one-cycle gap, then 2 more → out_valid pattern 1111 0 11 starting at t+8; each result matches the golden model.
- Shadow reload: stream 6 vectors while loading W2 mid-stream.
  - All 6 results use W1; w_pending=1 until drain, then w_ready stays 1 with W2.
  - The next vector uses W2.
- Errors: in_valid after reset → err=1, no out_valid. Then a 5th weight beat while W_FULL → err stays 1, shadow unchanged.
- Reset mid-stream: rst at t+3 after 3 launches → no out_valid afterwards, all outputs 0, w_ready=0.
